// File: rtl/cdp1802_uart.sv
// cdp1802_uart: byte-wide UART on the CDP1802 I/O bus. One TX holding
// register in front of a shift engine, one RX engine behind a two-flop
// synchroniser, and status reported on io_din and the EF flag lines.
//
// Bus strobes: io_out and io_inp are single-cycle strobes qualified by io_n.
// An OUT transfer completes on the edge that ends its io_out cycle. An INP
// transfer returns io_din during its io_inp cycle, and any read side effect
// takes place on the edge that ends that cycle. There is no back-pressure.
// Software polls EF[1] (tx_ready) before writing and EF[0] (rx_valid)
// before reading.
module cdp1802_uart #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [2:0]  TX_PORT      = 3'd1,
    parameter logic [2:0]  RX_PORT      = 3'd1,
    parameter logic [2:0]  STAT_PORT    = 3'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] io_n,
    input  logic       io_out,
    input  logic       io_inp,
    input  logic [7:0] io_dout,
    output logic [7:0] io_din,
    output logic [3:0] EF,
    input  logic       uart_rx,
    output logic       uart_tx
);

    // The bit-timing counter holds values 0..CLKS_PER_BIT-1.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // TX registers and their next values
    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_bit, tx_bit_n;
    logic [7:0]      tx_shift, tx_shift_n;
    logic            tx_line, tx_line_n;
    logic [7:0]      hold_reg, hold_reg_n;
    logic            hold_full, hold_full_n;
    logic            tx_load, tx_accept;

    // RX registers and their next values
    logic            rx_s1, rx_s2, rxs;
    state_t          rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_shift, rx_shift_n;
    logic [7:0]      rx_data, rx_data_n;
    logic            rx_valid, rx_valid_n;
    logic            rx_overrun, rx_overrun_n;
    logic            frame_err, frame_err_n;
    logic            rx_done, rx_good, rx_load;
    logic            rx_read, stat_read;

    assign rxs       = rx_s2;
    assign rx_read   = io_inp && (io_n == RX_PORT);
    assign stat_read = io_inp && (io_n == STAT_PORT);

    // TX engine next state; a load frees the holding slot on the same edge,
    // so a write arriving with the load is accepted.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_load    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (hold_full) begin
                    tx_load    = 1'b1;
                    tx_state_n = S_START;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    tx_line_n  = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (hold_full) begin
                        tx_load    = 1'b1;
                        tx_state_n = S_START;
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        if (tx_load) tx_shift_n = hold_reg;
        tx_accept   = io_out && (io_n == TX_PORT) && (!hold_full || tx_load);
        hold_reg_n  = tx_accept ? io_dout : hold_reg;
        hold_full_n = tx_accept ? 1'b1 : (tx_load ? 1'b0 : hold_full);
    end

    // RX engine next state and completion handling for data and flags
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rxs) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rxs ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rxs, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_done    = 1'b1;
                    rx_cnt_n   = '0;
                    rx_state_n = S_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
        rx_good      = rx_done && rxs;
        rx_load      = rx_good && (!rx_valid || rx_read);
        rx_data_n    = rx_load ? rx_shift : rx_data;
        rx_valid_n   = rx_load ? 1'b1 : (rx_read ? 1'b0 : rx_valid);
        rx_overrun_n = (rx_good && rx_valid && !rx_read) ? 1'b1
                     : (stat_read ? 1'b0 : rx_overrun);
        frame_err_n  = (rx_done && !rxs) ? 1'b1
                     : (stat_read ? 1'b0 : frame_err);
    end

    // State register for both engines, the synchroniser and the flags
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= 3'd0;
            tx_shift   <= 8'h00;
            tx_line    <= 1'b1;
            hold_reg   <= 8'h00;
            hold_full  <= 1'b0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            tx_state   <= tx_state_n;
            tx_cnt     <= tx_cnt_n;
            tx_bit     <= tx_bit_n;
            tx_shift   <= tx_shift_n;
            tx_line    <= tx_line_n;
            hold_reg   <= hold_reg_n;
            hold_full  <= hold_full_n;
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            rx_overrun <= rx_overrun_n;
            frame_err  <= frame_err_n;
        end
    end

    // Read mux depends on io_n and registers only, never on io_inp
    always_comb begin
        io_din = 8'h00;
        if (io_n == RX_PORT)        io_din = rx_data;
        else if (io_n == STAT_PORT) io_din = {4'b0000, rx_overrun, frame_err, ~hold_full, rx_valid};
    end

    assign EF      = {2'b00, ~hold_full, rx_valid};
    assign uart_tx = tx_line;

endmodule

// File: tb/tb_cdp1802_uart.sv
// Self-checking bench for cdp1802_uart: CPU bus driver tasks, a serial RX
// driver, and a frame/flag reference model built from the UART rules.
module tb_cdp1802_uart;

  localparam int CPB = 16;
  localparam logic [2:0] TXP = 3'd1;
  localparam logic [2:0] RXP = 3'd1;
  localparam logic [2:0] STP = 3'd2;

  logic       clock, reset;
  logic [2:0] io_n;
  logic       io_out, io_inp;
  logic [7:0] io_dout, io_din;
  logic [3:0] EF;
  logic       uart_rx, uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the receive-side flags and the TX holding slot
  logic [7:0] m_data;
  logic m_rxv, m_ovr, m_fe, m_hold;
  logic [7:0] exp_q[$];

  cdp1802_uart #(.CLKS_PER_BIT(CPB), .TX_PORT(TXP), .RX_PORT(RXP), .STAT_PORT(STP)) dut (
    .clock(clock), .reset(reset), .io_n(io_n), .io_out(io_out), .io_inp(io_inp),
    .io_dout(io_dout), .io_din(io_din), .EF(EF), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // serial frame: index 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[3'(idx - 1)];
    else return 1'b1;
  endfunction

  function automatic logic [7:0] status_word();
    return {4'b0000, m_ovr, m_fe, ~m_hold, m_rxv};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_rxv = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_hold = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic read_same);
    if (!stop) m_fe = 1'b1;
    else if (!m_rxv || read_same) begin m_data = d; m_rxv = 1'b1; end
    else m_ovr = 1'b1;
  endtask

  // driver tasks; every task starts and ends 1 ns after a rising edge
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    io_n = TXP; io_dout = d; io_out = 1'b1;
    tick();
    io_out = 1'b0; io_n = 3'd0;
  endtask

  task automatic cpu_read(input logic [2:0] port, output logic [7:0] d);
    io_n = port; io_inp = 1'b1;
    #2 d = io_din;
    tick();
    io_inp = 1'b0; io_n = 3'd0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 10; i++) begin
      uart_rx = (i == 9) ? stop : frame_bit(d, i);
      repeat (CPB) @(posedge clock);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int bad;
    n_checks++; if (EF !== 4'b0010) begin n_fail++; $display("FAIL reset_ef: got %b expected 0010", EF); end
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    io_n = 3'd0; #1;
    n_checks++; if (io_din !== 8'h00) begin n_fail++; $display("FAIL reset_din_other: got %h expected 00", io_din); end
    io_n = RXP; #1;
    n_checks++; if (io_din !== 8'h00) begin n_fail++; $display("FAIL reset_din_rx: got %h expected 00", io_din); end
    io_n = 3'd0;
    tick();
    cpu_write(8'h5A);
    repeat (40) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_tx: got %b expected 1", uart_tx); end
    tick();
    reset = 1'b0;
    model_reset();
    n_checks++; if (EF !== 4'b0010) begin n_fail++; $display("FAIL midframe_reset_ef: got %b expected 0010", EF); end
    cpu_read(STP, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL midframe_reset_stat: got %h expected 02", d); end
    bad = 0;
    for (int c = 0; c < 3 * CPB; c++) begin
      tick();
      if (uart_tx !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_no_frame: %0d low cycles, expected 0", bad); end
  endtask

  task automatic tx_frame_check(input logic [7:0] b, input string name);
    cpu_write(b);
    n_checks++; if (EF[1] !== 1'b0) begin n_fail++; $display("FAIL %s_ready_low: got %b expected 0", name, EF[1]); end
    for (int c = 0; c < 10 * CPB + 4; c++) begin
      tick();
      if (c == 0) begin
        n_checks++; if (EF[1] !== 1'b1) begin n_fail++; $display("FAIL %s_ready_back: got %b expected 1", name, EF[1]); end
      end
      n_checks++;
      if (uart_tx !== ((c < 10 * CPB) ? frame_bit(b, c / CPB) : 1'b1)) begin
        n_fail++; $display("FAIL %s_line c=%0d: got %b expected %b", name, c, uart_tx,
                           (c < 10 * CPB) ? frame_bit(b, c / CPB) : 1'b1);
      end
    end
  endtask

  task automatic test_tx_frame();
    tx_frame_check(8'hA5, "tx_a5");
  endtask

  task automatic test_tx_random();
    for (int k = 0; k < 3; k++) tx_frame_check(8'($urandom), "tx_rand");
  endtask

  task automatic test_back_to_back();
    logic [7:0] acc_q[$];
    logic line_q[$];
    logic [7:0] third;
    third = 8'($urandom);
    // 0x55 goes straight to the shifter, 0x0F lands in the empty slot,
    // the third write finds the slot occupied and is lost
    acc_q.push_back(8'h55);
    acc_q.push_back(8'h0F);
    foreach (acc_q[f]) for (int i = 0; i < 10 * CPB; i++) line_q.push_back(frame_bit(acc_q[f], i / CPB));
    for (int i = 0; i < 2 * CPB; i++) line_q.push_back(1'b1);
    cpu_write(8'h55);
    for (int c = 0; c < line_q.size(); c++) begin
      tick();
      io_out = 1'b0;
      n_checks++; if (uart_tx !== line_q[c]) begin n_fail++; $display("FAIL b2b_line c=%0d: got %b expected %b", c, uart_tx, line_q[c]); end
      if (c == 30) begin
        n_checks++; if (EF[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_full: got %b expected 0", EF[1]); end
      end
      if (c == 170) begin
        n_checks++; if (EF[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_drained: got %b expected 1", EF[1]); end
      end
      if (c == 2)  begin io_n = TXP; io_dout = 8'h0F; io_out = 1'b1; end
      if (c == 20) begin io_n = TXP; io_dout = third; io_out = 1'b1; end
    end
  endtask

  task automatic test_write_on_load();
    logic [7:0] b1, b2, b3;
    logic line_q[$];
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    // b2 arrives on the edge the shifter takes b1: accepted; b3 is dropped
    for (int i = 0; i < 10 * CPB; i++) line_q.push_back(frame_bit(b1, i / CPB));
    for (int i = 0; i < 10 * CPB; i++) line_q.push_back(frame_bit(b2, i / CPB));
    for (int i = 0; i < 2 * CPB; i++) line_q.push_back(1'b1);
    cpu_write(b1);
    io_n = TXP; io_dout = b2; io_out = 1'b1;
    for (int c = 0; c < line_q.size(); c++) begin
      tick();
      io_out = 1'b0;
      if (c == 0) begin
        n_checks++; if (EF[1] !== 1'b0) begin n_fail++; $display("FAIL wol_hold_full: got %b expected 0", EF[1]); end
      end
      n_checks++; if (uart_tx !== line_q[c]) begin n_fail++; $display("FAIL wol_line c=%0d: got %b expected %b", c, uart_tx, line_q[c]); end
      if (c == 5) begin io_n = TXP; io_dout = b3; io_out = 1'b1; end
    end
  endtask

  task automatic test_rx_byte();
    logic [7:0] d;
    n_checks++; if (EF[0] !== 1'b0) begin n_fail++; $display("FAIL rx_idle_flag: got %b expected 0", EF[0]); end
    send_rx(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b0);
    n_checks++; if (EF[0] !== m_rxv) begin n_fail++; $display("FAIL rx_flag_set: got %b expected %b", EF[0], m_rxv); end
    cpu_read(RXP, d);
    n_checks++; if (d !== m_data) begin n_fail++; $display("FAIL rx_data: got %h expected %h", d, m_data); end
    m_rxv = 1'b0;
    n_checks++; if (EF[0] !== m_rxv) begin n_fail++; $display("FAIL rx_flag_clear: got %b expected %b", EF[0], m_rxv); end
  endtask

  task automatic test_rx_random();
    logic [7:0] d, b;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_rx(b, 1'b1);
      model_frame(b, 1'b1, 1'b0);
      repeat ($urandom_range(0, 5)) tick();
      cpu_read(RXP, d);
      m_rxv = 1'b0;
      n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL rx_rand_data: got %h expected %h", d, exp_q[0]); end
      void'(exp_q.pop_front());
      cpu_read(STP, d);
      n_checks++; if (d !== status_word()) begin n_fail++; $display("FAIL rx_rand_stat: got %h expected %h", d, status_word()); end
      m_ovr = 1'b0; m_fe = 1'b0;
    end
  endtask

  task automatic test_rx_errors();
    logic [7:0] d;
    send_rx(8'h11, 1'b1); model_frame(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1); model_frame(8'h22, 1'b1, 1'b0);
    // fill the TX slot behind a running frame so tx_ready reads 0
    cpu_write(8'hC3);
    tick();
    cpu_write(8'h3C);
    m_hold = 1'b1;
    cpu_read(STP, d);
    n_checks++; if (d !== 8'h09 || d !== status_word()) begin n_fail++; $display("FAIL err_overrun_stat: got %h expected 09", d); end
    m_ovr = 1'b0; m_fe = 1'b0;
    cpu_read(RXP, d);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL err_kept_data: got %h expected 11", d); end
    m_rxv = 1'b0;
    repeat (20) tick();
    send_rx(8'h77, 1'b0); model_frame(8'h77, 1'b0, 1'b0);
    m_hold = 1'b0;
    cpu_read(STP, d);
    n_checks++; if (d !== status_word()) begin n_fail++; $display("FAIL err_frame_stat: got %h expected %h", d, status_word()); end
    m_ovr = 1'b0; m_fe = 1'b0;
    cpu_read(STP, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL err_cleared_stat: got %h expected 02", d); end
    repeat (400) tick();
    n_checks++; if (EF !== 4'b0010) begin n_fail++; $display("FAIL err_drained_ef: got %b expected 0010", EF); end
  endtask

  task automatic test_rx_glitch_collision();
    logic [7:0] d, old_d, a, b;
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (40) tick();
    n_checks++; if (EF !== 4'b0010) begin n_fail++; $display("FAIL glitch_ef: got %b expected 0010", EF); end
    cpu_read(STP, d);
    n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL glitch_stat: got %h expected 02", d); end
    a = 8'($urandom); b = ~a;
    send_rx(a, 1'b1); model_frame(a, 1'b1, 1'b0);
    // the second frame's stop sample falls 155 edges after its start bit begins
    fork
      send_rx(b, 1'b1);
      begin
        repeat (154) @(posedge clock);
        #1 io_n = RXP; io_inp = 1'b1;
        #2 old_d = io_din;
        @(posedge clock);
        #1 io_inp = 1'b0; io_n = 3'd0;
      end
    join
    n_checks++; if (old_d !== a) begin n_fail++; $display("FAIL coll_old_data: got %h expected %h", old_d, a); end
    model_frame(b, 1'b1, 1'b1);
    n_checks++; if (EF[0] !== 1'b1) begin n_fail++; $display("FAIL coll_valid: got %b expected 1", EF[0]); end
    cpu_read(STP, d);
    n_checks++; if (d !== status_word()) begin n_fail++; $display("FAIL coll_stat: got %h expected %h", d, status_word()); end
    cpu_read(RXP, d);
    n_checks++; if (d !== b) begin n_fail++; $display("FAIL coll_new_data: got %h expected %h", d, b); end
  endtask

  initial begin
    reset = 1'b1; io_n = 3'd0; io_out = 1'b0; io_inp = 1'b0; io_dout = 8'h00; uart_rx = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_tx_frame();
    test_tx_random();
    test_back_to_back();
    test_write_on_load();
    test_rx_byte();
    test_rx_random();
    test_rx_errors();
    test_rx_glitch_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
